// File: rtl/pll_lock_reset_seq_if.sv
// pll_lock_reset_seq_if: PLL lock input and reset-sequencer outputs.
// master = PLL/board side that drives lock; slave = the sequencer.
interface pll_lock_reset_seq_if #(
  parameter int CNT_W = 8
);
  logic             lock_async;
  logic             pll_rst;
  logic             rst_out;
  logic             ready;
  logic             lock_lost;
  logic [CNT_W-1:0] loss_count;
  modport master (
    output lock_async,
    input  pll_rst, rst_out, ready, lock_lost, loss_count
  );
  modport slave (
    input  lock_async,
    output pll_rst, rst_out, ready, lock_lost, loss_count
  );
endinterface

// File: rtl/pll_lock_reset_seq.sv
// pll_lock_reset_seq: qualifies the async rPLL lock and releases a clean synchronous reset.
// Optional feature macro AUTO_RETRY_EN: pulse pll_rst when lock fails to appear within TIMEOUT_CYCLES.
module pll_lock_reset_seq #(
  parameter int SYNC_STAGES    = 2,
  parameter int STABLE_CYCLES  = 1000,
  parameter int HOLD_CYCLES    = 16,
  parameter int TIMEOUT_CYCLES = 100000,
  parameter int PLL_RST_CYCLES = 100,
  parameter int CNT_W          = 8
) (
  input logic                clk,
  input logic                reset,
  pll_lock_reset_seq_if.slave bus
);
  localparam int MAX_A = STABLE_CYCLES > HOLD_CYCLES ? STABLE_CYCLES : HOLD_CYCLES;
`ifdef AUTO_RETRY_EN
  localparam int MAX_B = TIMEOUT_CYCLES > PLL_RST_CYCLES ? TIMEOUT_CYCLES : PLL_RST_CYCLES;
  localparam int MAX_C = MAX_A > MAX_B ? MAX_A : MAX_B;
`else
  localparam int MAX_C = MAX_A;
`endif
  localparam int CW = $clog2(MAX_C) + 1;
  if (SYNC_STAGES < 2 || STABLE_CYCLES < 1 || HOLD_CYCLES < 1 || TIMEOUT_CYCLES < 1 ||
      PLL_RST_CYCLES < 1 || CNT_W < 1) begin : g_bad_param
    $error("pll_lock_reset_seq: illegal parameter value");
  end
  typedef enum logic [2:0] {
    S_WAIT,
    S_STABLE,
    S_HOLD,
`ifdef AUTO_RETRY_EN
    S_PLLRST,
`endif
    S_RUN
  } state_t;
  state_t           r_state, w_next;
  logic [CW-1:0]    r_cnt, w_cnt_next, w_cnt_inc;
  logic [SYNC_STAGES-1:0] r_sync;
  logic             w_lock_s, w_loss;
  logic             r_rst_out, r_ready, r_lock_lost;
  logic [CNT_W-1:0] r_loss_count;
  assign w_lock_s  = r_sync[SYNC_STAGES-1];
  assign w_cnt_inc = r_cnt + CW'(1);
  // one shared counter: every state change clears it, so it never wraps
  always_comb begin
    w_next     = r_state;
    w_cnt_next = w_cnt_inc;
    w_loss     = 1'b0;
    case (r_state)
      S_WAIT: begin
`ifdef AUTO_RETRY_EN
        w_next = w_lock_s ? S_STABLE : w_cnt_inc == CW'(TIMEOUT_CYCLES) ? S_PLLRST : S_WAIT;
`else
        w_next     = w_lock_s ? S_STABLE : S_WAIT;
        w_cnt_next = '0;
`endif
      end
      S_STABLE: w_next = !w_lock_s ? S_WAIT : w_cnt_inc == CW'(STABLE_CYCLES) ? S_HOLD : S_STABLE;
      S_HOLD:   w_next = !w_lock_s ? S_WAIT : w_cnt_inc == CW'(HOLD_CYCLES) ? S_RUN : S_HOLD;
`ifdef AUTO_RETRY_EN
      S_PLLRST: w_next = w_cnt_inc == CW'(PLL_RST_CYCLES) ? S_WAIT : S_PLLRST;
`endif
      S_RUN: begin
        w_next     = w_lock_s ? S_RUN : S_WAIT;
        w_loss     = !w_lock_s;
        w_cnt_next = '0;
      end
      default: w_next = S_WAIT;
    endcase
    if (w_next != r_state) w_cnt_next = '0;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= S_WAIT;
      r_cnt        <= '0;
      r_sync       <= '0;
      r_rst_out    <= 1'b1;
      r_ready      <= 1'b0;
      r_lock_lost  <= 1'b0;
      r_loss_count <= '0;
    end else begin
      r_state     <= w_next;
      r_cnt       <= w_cnt_next;
      r_sync      <= {r_sync[SYNC_STAGES-2:0], bus.lock_async};
      r_rst_out   <= w_next != S_RUN;
      r_ready     <= w_next == S_RUN;
      r_lock_lost <= w_loss;
      if (w_loss && r_loss_count != '1) r_loss_count <= r_loss_count + CNT_W'(1);
    end
  end
`ifdef AUTO_RETRY_EN
  logic r_pll_rst;
  always_ff @(posedge clk) r_pll_rst <= reset ? 1'b0 : w_next == S_PLLRST;
  assign bus.pll_rst = r_pll_rst;
`else
  assign bus.pll_rst = 1'b0;
`endif
  assign bus.rst_out    = r_rst_out;
  assign bus.ready      = r_ready;
  assign bus.lock_lost  = r_lock_lost;
  assign bus.loss_count = r_loss_count;
endmodule
